// File: rtl/cntr8_os_reg.sv
// Registered 8-bit up/down/load counter stage with wrap flags.
// The state is supplied by external next-state logic; this block registers it and the count.
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | count cleared to zero
// LOAD  | count takes d_in, flags cleared
// INC   | count + 1, carry flagged on wrap FF->00
// INC2  | same arithmetic as INC
// DEC   | count - 1, borrow flagged on wrap 00->FF
// DEC2  | same arithmetic as DEC
// 110/111 are illegal and fall back to IDLE

module cntr8_os_reg (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] next_state,
    input  logic [7:0] d_in,
    output logic [2:0] state,
    output logic [7:0] d_out,
    output logic       o_carry,
    output logic       o_borrow
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_LOAD = 3'b001,
        ST_INC  = 3'b010,
        ST_INC2 = 3'b011,
        ST_DEC  = 3'b100,
        ST_DEC2 = 3'b101
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       carry_q, carry_d;
    logic       borrow_q, borrow_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'h00;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    // Decode acts on the state being entered, so d_out trails next_state by one edge.
    always_comb begin
        state_d  = ST_IDLE;
        cnt_d    = 8'h00;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        case (next_state)
            3'b001: begin
                state_d = ST_LOAD;
                cnt_d   = d_in;
            end
            3'b010, 3'b011: begin
                state_d = (next_state[0]) ? ST_INC2 : ST_INC;
                cnt_d   = cnt_q + 8'd1;
                carry_d = (cnt_q == 8'hFF);
            end
            3'b100, 3'b101: begin
                state_d  = (next_state[0]) ? ST_DEC2 : ST_DEC;
                cnt_d    = cnt_q - 8'd1;
                borrow_d = (cnt_q == 8'h00);
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'h00;
            end
        endcase
    end

    assign state    = state_q;
    assign d_out    = cnt_q;
    assign o_carry  = carry_q;
    assign o_borrow = borrow_q;

endmodule

// File: tb/tb_cntr8_os_reg.sv
// Directed bench for cntr8_os_reg: vector table plus hand-written reset corner cases.

module tb_cntr8_os_reg;

    logic       clk;
    logic       reset_n;
    logic [2:0] next_state;
    logic [7:0] d_in;
    logic [2:0] state;
    logic [7:0] d_out;
    logic       o_carry;
    logic       o_borrow;

    int checks   = 0;
    int failures = 0;

    cntr8_os_reg dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .next_state (next_state),
        .d_in       (d_in),
        .state      (state),
        .d_out      (d_out),
        .o_carry    (o_carry),
        .o_borrow   (o_borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ns;
        logic [7:0] din;
        logic [2:0] e_state;
        logic [7:0] e_dout;
        logic       e_carry;
        logic       e_borrow;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] s, input logic [7:0] d,
                           input logic c, input logic b);
        chk({tag, ".state"},  {5'd0, state}, {5'd0, s});
        chk({tag, ".d_out"},  d_out, d);
        chk({tag, ".carry"},  {7'd0, o_carry}, {7'd0, c});
        chk({tag, ".borrow"}, {7'd0, o_borrow}, {7'd0, b});
    endtask

    task automatic step(input logic [2:0] ns, input logic [7:0] din);
        next_state = ns;
        d_in       = din;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [2:0] ns, input logic [7:0] din, input logic [2:0] s,
                       input logic [7:0] d, input logic c, input logic b);
        vec_t v;
        v.ns = ns; v.din = din; v.e_state = s; v.e_dout = d; v.e_carry = c; v.e_borrow = b;
        vecs.push_back(v);
    endtask

    initial begin
        // Sequential vectors: each row's expectation depends on the previous rows.
        add(3'b001, 8'h3C, 3'b001, 8'h3C, 0, 0);
        add(3'b001, 8'hFE, 3'b001, 8'hFE, 0, 0);
        add(3'b010, 8'h00, 3'b010, 8'hFF, 0, 0);
        add(3'b011, 8'h00, 3'b011, 8'h00, 1, 0);
        add(3'b010, 8'h00, 3'b010, 8'h01, 0, 0);
        add(3'b001, 8'h01, 3'b001, 8'h01, 0, 0);
        add(3'b100, 8'h00, 3'b100, 8'h00, 0, 0);
        add(3'b101, 8'h00, 3'b101, 8'hFF, 0, 1);
        add(3'b100, 8'h00, 3'b100, 8'hFE, 0, 0);
        add(3'b001, 8'h03, 3'b001, 8'h03, 0, 0);
        add(3'b010, 8'h00, 3'b010, 8'h04, 0, 0);
        add(3'b011, 8'h00, 3'b011, 8'h05, 0, 0);
        add(3'b111, 8'h55, 3'b000, 8'h00, 0, 0);
        add(3'b000, 8'h55, 3'b000, 8'h00, 0, 0);
        add(3'b000, 8'h55, 3'b000, 8'h00, 0, 0);
        add(3'b000, 8'h55, 3'b000, 8'h00, 0, 0);
        add(3'b001, 8'h10, 3'b001, 8'h10, 0, 0);
        add(3'b110, 8'h10, 3'b000, 8'h00, 0, 0);
        add(3'b001, 8'hFF, 3'b001, 8'hFF, 0, 0);
        add(3'b010, 8'h00, 3'b010, 8'h00, 1, 0);
        add(3'b001, 8'hFF, 3'b001, 8'hFF, 0, 0);
        add(3'b001, 8'h00, 3'b001, 8'h00, 0, 0);
        add(3'b100, 8'h00, 3'b100, 8'hFF, 0, 1);
        add(3'b001, 8'h00, 3'b001, 8'h00, 0, 0);
        add(3'b010, 8'h00, 3'b010, 8'h01, 0, 0);
        add(3'b011, 8'h00, 3'b011, 8'h02, 0, 0);
        add(3'b010, 8'h00, 3'b010, 8'h03, 0, 0);
        add(3'b011, 8'h00, 3'b011, 8'h04, 0, 0);
        add(3'b101, 8'h00, 3'b101, 8'h03, 0, 0);
        add(3'b100, 8'h00, 3'b100, 8'h02, 0, 0);

        reset_n    = 1'b0;
        next_state = 3'b001;
        d_in       = 8'hAA;
        #12;
        chk_all("reset", 3'b000, 8'h00, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].ns, vecs[i].din);
            chk_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_dout,
                    vecs[i].e_carry, vecs[i].e_borrow);
        end

        // Asynchronous reset mid-count, between edges, with INC still applied.
        step(3'b001, 8'h7F);
        step(3'b010, 8'h00);
        chk_all("pre_rst", 3'b010, 8'h80, 0, 0);
        #2 reset_n = 1'b0;
        #1 chk_all("async_rst", 3'b000, 8'h00, 0, 0);
        #1 reset_n = 1'b1;
        step(3'b010, 8'h00);
        chk_all("post_rst", 3'b010, 8'h01, 0, 0);

        // Reset must also clear a pending carry flag immediately.
        step(3'b001, 8'hFF);
        step(3'b011, 8'h00);
        chk_all("carry_set", 3'b011, 8'h00, 1, 0);
        #2 reset_n = 1'b0;
        #1 chk_all("carry_rst", 3'b000, 8'h00, 0, 0);
        #1 reset_n = 1'b1;
        step(3'b100, 8'h00);
        chk_all("borrow_after_rst", 3'b100, 8'hFF, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cntr8_os_reg.md
CNTR8_OS_REG -- requirements
Module: cntr8_os_reg

Interface
REQ-001 The block SHALL have no parameters; the count width is fixed at 8 bits and the state width at 3 bits.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low, with ports named clk and reset_n.
REQ-003 Port clk  input  1  rising-edge clock for all registers.
REQ-004 Port reset_n  input  1  asynchronous active-low reset.
REQ-005 Port next_state  input  3  state code from the counter next-state logic.
REQ-006 Port d_in  input  8  parallel load value.
REQ-007 Port state  output  3  registered current state, fed back to the next-state logic.
REQ-008 Port d_out  output  8  registered count value.
REQ-009 Port o_carry  output  1  registered increment-wrap flag.
REQ-010 Port o_borrow  output  1  registered decrement-wrap flag.

Function
REQ-011 State encoding SHALL be: IDLE=000, LOAD=001, INC=010, INC2=011, DEC=100, DEC2=101; codes 110 and 111 are illegal.
REQ-012 On every rising clk edge with reset_n high, state SHALL take next_state, or IDLE if next_state is illegal.
REQ-013 On the same edge, d_out SHALL update according to the decoded next_state (the state being entered), giving one-cycle latency from next_state to d_out.
REQ-014 IDLE: d_out SHALL become 8'h00.
REQ-015 LOAD: d_out SHALL become d_in as sampled at that edge.
REQ-016 INC or INC2: d_out SHALL become (d_out + 1) mod 256.
REQ-017 DEC or DEC2: d_out SHALL become (d_out - 1) mod 256.
REQ-018 Illegal next_state: d_out SHALL become 8'h00 (same as IDLE).
REQ-019 o_carry SHALL be 1 for exactly the cycle following an INC/INC2 update where d_out was 8'hFF (wrap to 8'h00), and 0 otherwise.
REQ-020 o_borrow SHALL be 1 for exactly the cycle following a DEC/DEC2 update where d_out was 8'h00 (wrap to 8'hFF), and 0 otherwise.
REQ-021 o_carry and o_borrow SHALL never both be 1.
REQ-022 LOAD SHALL clear both flags, including LOAD of 8'h00 or 8'hFF.
REQ-023 Repeated INC/INC2 alternation SHALL count continuously; the INC/INC2 distinction SHALL NOT change the arithmetic.
REQ-024 Repeated DEC/DEC2 alternation SHALL likewise count down continuously.
REQ-025 The block SHALL contain no combinational path from any input to any output.

Reset
REQ-026 When reset_n is low, the block SHALL asynchronously force state=000, d_out=8'h00, o_carry=0, o_borrow=0, regardless of clk.
REQ-027 Reset asserted mid-count SHALL discard the count immediately, without waiting for a clock edge.
REQ-028 After reset_n deasserts, the first rising edge SHALL apply next_state normally.
REQ-029 Reset deassertion coincident with a clk edge SHALL NOT be required to capture that edge.

Verification
REQ-030 Reset, then next_state=LOAD with d_in=8'h3C for one edge -> state=001, d_out=8'h3C, both flags 0.
REQ-031 LOAD 8'hFE, then INC, INC2, INC -> d_out sequence 8'hFF, 8'h00 (o_carry=1 that cycle only), 8'h01 (o_carry=0).
REQ-032 LOAD 8'h01, then DEC, DEC2, DEC -> d_out sequence 8'h00, 8'hFF (o_borrow=1 that cycle only), 8'hFE.
REQ-033 Count to 8'h05, then next_state=111 -> state=000, d_out=8'h00; then IDLE held for 3 edges -> outputs unchanged.
REQ-034 Count at 8'h80 with INC applied, reset_n pulsed low between edges -> d_out=8'h00 and state=000 immediately; first edge after release with next_state=INC -> d_out=8'h01.
REQ-035 LOAD 8'hFF, then INC -> d_out=8'h00 with o_carry=1; then LOAD 8'hFF -> o_carry=0.
